// File: rtl/xc_malu_step_ctrl_if.sv
// Core request/response and MALU datapath step bundle for xc_malu_step_ctrl.
// slave = the controller's view; master = the core plus datapath side.
interface xc_malu_step_ctrl_if;
    // Core request channel
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [31:0] req_rs3;
    logic [9:0]  req_op;
    logic [4:0]  req_pw;
    logic        flush;

    // Core response channel
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_result;
    logic        rsp_err;

    // Datapath step interface
    logic        dp_valid;
    logic        dp_flush;
    logic [31:0] dp_rs1;
    logic [31:0] dp_rs2;
    logic [31:0] dp_rs3;
    logic [9:0]  dp_op;
    logic [4:0]  dp_pw;
    logic [5:0]  dp_count;
    logic [63:0] dp_acc;
    logic [31:0] dp_arg_0;
    logic [31:0] dp_arg_1;
    logic [63:0] dp_n_acc;
    logic [31:0] dp_n_arg_0;
    logic [31:0] dp_n_arg_1;
    logic [63:0] dp_result;
    logic        dp_ready;

    modport slave (
        input  req_valid, req_rs1, req_rs2, req_rs3, req_op, req_pw, flush,
        output req_ready,
        input  rsp_ready,
        output rsp_valid, rsp_result, rsp_err,
        output dp_valid, dp_flush, dp_rs1, dp_rs2, dp_rs3, dp_op, dp_pw,
        output dp_count, dp_acc, dp_arg_0, dp_arg_1,
        input  dp_n_acc, dp_n_arg_0, dp_n_arg_1, dp_result, dp_ready
    );

    modport master (
        output req_valid, req_rs1, req_rs2, req_rs3, req_op, req_pw, flush,
        input  req_ready,
        output rsp_ready,
        input  rsp_valid, rsp_result, rsp_err,
        input  dp_valid, dp_flush, dp_rs1, dp_rs2, dp_rs3, dp_op, dp_pw,
        input  dp_count, dp_acc, dp_arg_0, dp_arg_1,
        output dp_n_acc, dp_n_arg_0, dp_n_arg_1, dp_result, dp_ready
    );
endinterface

// File: rtl/xc_malu_step_ctrl.sv
// IDLE/RUN/DONE sequencer owning the MALU operand and iteration registers.
// One RUN cycle per datapath step; the result is held in DONE until rsp_ready.
module xc_malu_step_ctrl #(
    parameter int unsigned MAX_COUNT = 63
) (
    input  logic                 clock,
    input  logic                 resetn,
    xc_malu_step_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [5:0] COUNT_LIMIT = 6'(MAX_COUNT);

    state_t      state;
    logic [31:0] rs1_q;
    logic [31:0] rs2_q;
    logic [31:0] rs3_q;
    logic [9:0]  op_q;
    logic [4:0]  pw_q;
    logic [5:0]  count_q;
    logic [63:0] acc_q;
    logic [31:0] arg_0_q;
    logic [31:0] arg_1_q;
    logic [63:0] result_q;
    logic        err_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic        dp_valid_q;
    logic        dp_flush_q;
    logic        op_legal;

    function automatic logic one_hot_10(input logic [9:0] v);
        return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
    endfunction

    function automatic logic one_hot_5(input logic [4:0] v);
        return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
    endfunction

    // Packed-width flags only matter for pmul (bit 8) and pclmul (bit 9).
    assign op_legal = one_hot_10(bus.req_op) &&
                      (!(bus.req_op[8] || bus.req_op[9]) || one_hot_5(bus.req_pw));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rs3_q       <= '0;
            op_q        <= '0;
            pw_q        <= '0;
            count_q     <= '0;
            acc_q       <= '0;
            arg_0_q     <= '0;
            arg_1_q     <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            dp_valid_q  <= 1'b0;
            dp_flush_q  <= 1'b0;
        end else begin
            dp_flush_q <= bus.flush;
            if (bus.flush) begin
                state       <= IDLE;
                rs1_q       <= '0;
                rs2_q       <= '0;
                rs3_q       <= '0;
                op_q        <= '0;
                pw_q        <= '0;
                count_q     <= '0;
                acc_q       <= '0;
                arg_0_q     <= '0;
                arg_1_q     <= '0;
                result_q    <= '0;
                err_q       <= 1'b0;
                req_ready_q <= 1'b1;
                rsp_valid_q <= 1'b0;
                dp_valid_q  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.req_valid) begin
                            rs1_q       <= bus.req_rs1;
                            rs2_q       <= bus.req_rs2;
                            rs3_q       <= bus.req_rs3;
                            op_q        <= bus.req_op;
                            pw_q        <= bus.req_pw;
                            count_q     <= '0;
                            acc_q       <= '0;
                            arg_0_q     <= bus.req_rs1;
                            arg_1_q     <= '0;
                            req_ready_q <= 1'b0;
                            if (op_legal) begin
                                state      <= RUN;
                                dp_valid_q <= 1'b1;
                            end else begin
                                state       <= DONE;
                                result_q    <= '0;
                                err_q       <= 1'b1;
                                rsp_valid_q <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (bus.dp_ready) begin
                            state       <= DONE;
                            result_q    <= bus.dp_result;
                            err_q       <= 1'b0;
                            dp_valid_q  <= 1'b0;
                            rsp_valid_q <= 1'b1;
                        end else if (count_q == COUNT_LIMIT) begin
                            state       <= DONE;
                            result_q    <= '0;
                            err_q       <= 1'b1;
                            dp_valid_q  <= 1'b0;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            count_q <= count_q + 6'd1;
                            acc_q   <= bus.dp_n_acc;
                            arg_0_q <= bus.dp_n_arg_0;
                            arg_1_q <= bus.dp_n_arg_1;
                        end
                    end
                    DONE: begin
                        // req_ready only rises after the handshake edge, so no
                        // request can be taken in the handshake cycle itself.
                        if (bus.rsp_ready) begin
                            state       <= IDLE;
                            rsp_valid_q <= 1'b0;
                            req_ready_q <= 1'b1;
                        end
                    end
                    default: begin
                        state       <= IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        dp_valid_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_err    = err_q;

    assign bus.dp_valid   = dp_valid_q;
    assign bus.dp_flush   = dp_flush_q;
    assign bus.dp_rs1     = rs1_q;
    assign bus.dp_rs2     = rs2_q;
    assign bus.dp_rs3     = rs3_q;
    assign bus.dp_op      = dp_valid_q ? op_q : 10'd0;
    assign bus.dp_pw      = pw_q;
    assign bus.dp_count   = count_q;
    assign bus.dp_acc     = acc_q;
    assign bus.dp_arg_0   = arg_0_q;
    assign bus.dp_arg_1   = arg_1_q;

endmodule

// File: tb/tb_xc_malu_step_ctrl.sv
// Directed bench for xc_malu_step_ctrl with a behavioural step datapath stub.
module tb_xc_malu_step_ctrl;

    logic       clock;
    logic       resetn;
    logic [6:0] ready_at;
    int         n_cmp;
    int         n_err;

    xc_malu_step_ctrl_if bus ();

    xc_malu_step_ctrl #(.MAX_COUNT(63)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [63:0] dp_model(input logic [9:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] q;
        logic signed [63:0] pa;
        logic signed [63:0] pb;
        sa = a;
        sb = b;
        pa = 64'(sa);
        pb = 64'(sb);
        case (op)
            10'h001: begin q = sa / sb; return {32'h0, q}; end
            10'h002: return {32'h0, a / b};
            10'h004: begin q = sa % sb; return {32'h0, q}; end
            10'h010: return pa * pb;
            10'h020: return {32'h0, a} * {32'h0, b};
            default: return 64'h0000_0000_DEAD_BEEF;
        endcase
    endfunction

    // Stub datapath: signals ready when the count reaches ready_at (127 = never).
    always_comb begin
        bus.dp_ready   = bus.dp_valid && ({1'b0, bus.dp_count} == ready_at);
        bus.dp_result  = dp_model(bus.dp_op, bus.dp_rs1, bus.dp_rs2);
        bus.dp_n_acc   = bus.dp_acc + 64'd3;
        bus.dp_n_arg_0 = bus.dp_arg_0 + 32'd1;
        bus.dp_n_arg_1 = bus.dp_arg_1 + 32'd2;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_req(input string tag, input logic [9:0] op, input logic [4:0] pw,
                          input logic [31:0] a, input logic [31:0] b);
        check({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_pw    = pw;
        bus.req_rs1   = a;
        bus.req_rs2   = b;
        bus.req_rs3   = 32'h1234_5678;
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int bound);
        int i;
        i = 0;
        while (!bus.rsp_valid && i < bound) begin
            step();
            i++;
        end
        check({tag, "_rsp_seen"}, 64'(bus.rsp_valid), 64'd1);
    endtask

    task automatic take_rsp(input string tag);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check({tag, "_rsp_dropped"}, 64'(bus.rsp_valid), 64'd0);
        check({tag, "_idle_ready"}, 64'(bus.req_ready), 64'd1);
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        ready_at      = 7'd127;
        resetn        = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_rs1   = '0;
        bus.req_rs2   = '0;
        bus.req_rs3   = '0;
        bus.req_op    = '0;
        bus.req_pw    = '0;
        bus.flush     = 1'b0;
        bus.rsp_ready = 1'b0;

        #12;
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_err",   64'(bus.rsp_err),   64'd0);
        check("rst_dp_valid",  64'(bus.dp_valid),  64'd0);
        check("rst_dp_flush",  64'(bus.dp_flush),  64'd0);
        check("rst_dp_count",  64'(bus.dp_count),  64'd0);
        check("rst_dp_acc",    bus.dp_acc,         64'd0);
        check("rst_dp_op",     64'(bus.dp_op),     64'd0);
        @(negedge clock);
        resetn = 1'b1;
        step();

        // mulu 3*5
        ready_at = 7'd2;
        do_req("mulu", 10'h020, 5'h00, 32'd3, 32'd5);
        check("mulu_dp_valid", 64'(bus.dp_valid), 64'd1);
        check("mulu_dp_op",    64'(bus.dp_op),    64'h020);
        check("mulu_count0",   64'(bus.dp_count), 64'd0);
        check("mulu_arg_0",    64'(bus.dp_arg_0), 64'd3);
        check("mulu_arg_1",    64'(bus.dp_arg_1), 64'd0);
        check("mulu_busy",     64'(bus.req_ready), 64'd0);
        wait_rsp("mulu", 65);
        check("mulu_result", bus.rsp_result, 64'h0000_0000_0000_000F);
        check("mulu_err",    64'(bus.rsp_err), 64'd0);
        take_rsp("mulu");

        // signed div and rem of -7 by 2
        ready_at = 7'd0;
        do_req("div", 10'h001, 5'h00, 32'hFFFF_FFF9, 32'd2);
        wait_rsp("div", 65);
        check("div_result", bus.rsp_result, 64'h0000_0000_FFFF_FFFD);
        check("div_err",    64'(bus.rsp_err), 64'd0);
        take_rsp("div");
        do_req("rem", 10'h004, 5'h00, 32'hFFFF_FFF9, 32'd2);
        wait_rsp("rem", 65);
        check("rem_result", bus.rsp_result, 64'h0000_0000_FFFF_FFFF);
        take_rsp("rem");

        // Ready at count 4, response back-pressured for 10 cycles
        ready_at = 7'd4;
        do_req("hold", 10'h010, 5'h00, 32'd7, 32'd9);
        for (int i = 0; i < 4; i++) step();
        check("hold_count4", 64'(bus.dp_count), 64'd4);
        check("hold_acc",    bus.dp_acc,         64'd12);
        check("hold_arg_0",  64'(bus.dp_arg_0), 64'd11);
        check("hold_arg_1",  64'(bus.dp_arg_1), 64'd8);
        step();
        for (int i = 0; i < 10; i++) begin
            check("hold_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            check("hold_result",    bus.rsp_result,      64'h3F);
            check("hold_req_ready", 64'(bus.req_ready), 64'd0);
            step();
        end
        check("hold_count_frozen", 64'(bus.dp_count), 64'd4);
        check("hold_acc_frozen",   bus.dp_acc,         64'd12);
        check("hold_dp_valid",     64'(bus.dp_valid), 64'd0);
        check("hold_dp_op",        64'(bus.dp_op),    64'd0);
        take_rsp("hold");

        // Illegal encodings go straight to DONE
        do_req("ill2", 10'h003, 5'h00, 32'd1, 32'd1);
        check("ill2_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("ill2_err",       64'(bus.rsp_err),   64'd1);
        check("ill2_result",    bus.rsp_result,      64'd0);
        check("ill2_dp_valid",  64'(bus.dp_valid),  64'd0);
        take_rsp("ill2");
        do_req("illpw", 10'h100, 5'b00011, 32'd1, 32'd1);
        check("illpw_err",      64'(bus.rsp_err),   64'd1);
        check("illpw_dp_valid", 64'(bus.dp_valid),  64'd0);
        take_rsp("illpw");

        // Legal pmul with a single packed width
        ready_at = 7'd0;
        do_req("pmul", 10'h100, 5'b00100, 32'd1, 32'd1);
        check("pmul_dp_valid", 64'(bus.dp_valid), 64'd1);
        check("pmul_dp_pw",    64'(bus.dp_pw),    64'h04);
        check("pmul_dp_op",    64'(bus.dp_op),    64'h100);
        step();
        check("pmul_err", 64'(bus.rsp_err), 64'd0);
        take_rsp("pmul");

        // Timeout: count runs 0..63 then errors
        ready_at = 7'd127;
        do_req("tmo", 10'h010, 5'h00, 32'd5, 32'd5);
        for (int i = 0; i < 64; i++) begin
            check("tmo_count", 64'(bus.dp_count), 64'(i));
            check("tmo_dp_valid", 64'(bus.dp_valid), 64'd1);
            step();
        end
        check("tmo_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("tmo_err",       64'(bus.rsp_err),   64'd1);
        check("tmo_result",    bus.rsp_result,      64'd0);
        check("tmo_count_sat", 64'(bus.dp_count), 64'd63);
        take_rsp("tmo");

        // Flush at count 7 of a divu
        ready_at = 7'd20;
        do_req("fl", 10'h002, 5'h00, 32'd100, 32'd7);
        for (int i = 0; i < 20 && bus.dp_count != 6'd7; i++) step();
        check("fl_count7", 64'(bus.dp_count), 64'd7);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("fl_dp_flush",  64'(bus.dp_flush),  64'd1);
        check("fl_req_ready", 64'(bus.req_ready), 64'd1);
        check("fl_count",     64'(bus.dp_count),  64'd0);
        check("fl_acc",       bus.dp_acc,          64'd0);
        check("fl_dp_valid",  64'(bus.dp_valid),  64'd0);
        check("fl_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        step();
        check("fl_dp_flush_end", 64'(bus.dp_flush),  64'd0);
        check("fl_no_rsp",       64'(bus.rsp_valid), 64'd0);
        ready_at = 7'd1;
        do_req("fl_mul", 10'h010, 5'h00, 32'd2, 32'd3);
        wait_rsp("fl_mul", 65);
        check("fl_mul_result", bus.rsp_result, 64'd6);
        check("fl_mul_err",    64'(bus.rsp_err), 64'd0);
        take_rsp("fl_mul");

        // Flush beats a simultaneous request
        bus.req_valid = 1'b1;
        bus.req_op    = 10'h010;
        bus.flush     = 1'b1;
        step();
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        check("flreq_dp_valid",  64'(bus.dp_valid),  64'd0);
        check("flreq_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("flreq_req_ready", 64'(bus.req_ready), 64'd1);

        // Flush beats a response handshake and discards the held error
        do_req("fldone", 10'h003, 5'h00, 32'd0, 32'd0);
        check("fldone_err_set", 64'(bus.rsp_err), 64'd1);
        bus.flush     = 1'b1;
        bus.rsp_ready = 1'b1;
        step();
        bus.flush     = 1'b0;
        bus.rsp_ready = 1'b0;
        check("fldone_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("fldone_err_clr",   64'(bus.rsp_err),   64'd0);
        check("fldone_req_ready", 64'(bus.req_ready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
